// File: rtl/control_sequencer_if.sv
// Bundle of the T-state/opcode inputs and control outputs of the SAP-1 control sequencer.
// The master modport is the ring counter/IR side; the slave modport is the sequencer.
interface control_sequencer_if;
    logic [3:0]  state;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic        halt;
    logic        exec;
    logic        err;

    modport master (output state, output opcode, input con, input halt, input exec, input err);
    modport slave  (input state, input opcode, output con, output halt, output exec, output err);
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: decodes the one-hot T-state and opcode into the 12-bit control word,
// running LDA/ADD/SUB over a second ring pass, latching HLT and flagging illegal T-states.
module control_sequencer (
    input  logic                CLK,
    input  logic                nCLR,
    control_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_FETCH = 2'b00,
        MODE_EXEC  = 2'b01,
        MODE_HALT  = 2'b10
    } mode_e;

    localparam logic [11:0] CON_IDLE = 12'h3E3;
    localparam logic [3:0]  OP_LDA = 4'b0000;
    localparam logic [3:0]  OP_ADD = 4'b0001;
    localparam logic [3:0]  OP_SUB = 4'b0010;
    localparam logic [3:0]  OP_OUT = 4'b1110;
    localparam logic [3:0]  OP_HLT = 4'b1111;
    localparam logic [3:0]  ST_T1 = 4'b0001;
    localparam logic [3:0]  ST_T2 = 4'b0010;
    localparam logic [3:0]  ST_T3 = 4'b0100;
    localparam logic [3:0]  ST_T4 = 4'b1000;

    // Bit positions within {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
    localparam int B_CP  = 11;
    localparam int B_EP  = 10;
    localparam int B_NLM = 9;
    localparam int B_NCE = 8;
    localparam int B_NLI = 7;
    localparam int B_NEI = 6;
    localparam int B_NLA = 5;
    localparam int B_EA  = 4;
    localparam int B_SU  = 3;
    localparam int B_EU  = 2;
    localparam int B_NLB = 1;
    localparam int B_NLO = 0;

    mode_e       mode_q, mode_d;
    logic [3:0]  op_q, op_d;
    logic        err_q, err_d;
    logic        state_ok_s;
    logic        state_run_s;
    logic [11:0] con_s;

    function automatic logic state_legal(input logic [3:0] s);
        logic ok;
        case (s)
            4'b0000, ST_T1, ST_T2, ST_T3, ST_T4: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign state_ok_s  = state_legal(bus.state);
    assign state_run_s = state_ok_s && (bus.state != 4'b0000);

    // Next-state: mode transitions only on a legal T4, sticky illegal-state flag
    always_comb begin
        mode_d = mode_q;
        op_d   = op_q;
        err_d  = err_q;
        if (!state_ok_s) begin
            err_d = 1'b1;
        end else begin
            case (mode_q)
                MODE_FETCH: begin
                    if (bus.state == ST_T4) begin
                        case (bus.opcode)
                            OP_LDA, OP_ADD, OP_SUB: begin
                                mode_d = MODE_EXEC;
                                op_d   = bus.opcode;
                            end
                            OP_HLT:  mode_d = MODE_HALT;
                            default: mode_d = MODE_FETCH;
                        endcase
                    end else begin
                        mode_d = MODE_FETCH;
                    end
                end
                MODE_EXEC: begin
                    if (bus.state == ST_T4) begin
                        mode_d = MODE_FETCH;
                    end else begin
                        mode_d = MODE_EXEC;
                    end
                end
                MODE_HALT: mode_d = MODE_HALT;
                default:   mode_d = MODE_FETCH;
            endcase
        end
    end

    // State register with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            mode_q <= MODE_FETCH;
            op_q   <= 4'b0000;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            op_q   <= op_d;
            err_q  <= err_d;
        end
    end

    // Control word decode; fetch T4 uses the live opcode, exec pass uses the latched one
    always_comb begin
        con_s = CON_IDLE;
        if (!nCLR || (mode_q == MODE_HALT) || !state_run_s) begin
            con_s = CON_IDLE;
        end else if (mode_q == MODE_FETCH) begin
            case (bus.state)
                ST_T1: begin
                    con_s[B_EP]  = 1'b1;
                    con_s[B_NLM] = 1'b0;
                end
                ST_T2: con_s[B_CP] = 1'b1;
                ST_T3: begin
                    con_s[B_NCE] = 1'b0;
                    con_s[B_NLI] = 1'b0;
                end
                ST_T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            con_s[B_NEI] = 1'b0;
                            con_s[B_NLM] = 1'b0;
                        end
                        OP_OUT: begin
                            con_s[B_EA]  = 1'b1;
                            con_s[B_NLO] = 1'b0;
                        end
                        default: con_s = CON_IDLE;
                    endcase
                end
                default: con_s = CON_IDLE;
            endcase
        end else begin
            case (bus.state)
                ST_T1: begin
                    case (op_q)
                        OP_LDA: begin
                            con_s[B_NCE] = 1'b0;
                            con_s[B_NLA] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            con_s[B_NCE] = 1'b0;
                            con_s[B_NLB] = 1'b0;
                        end
                        default: con_s = CON_IDLE;
                    endcase
                end
                ST_T2: begin
                    case (op_q)
                        OP_ADD: begin
                            con_s[B_EU]  = 1'b1;
                            con_s[B_NLA] = 1'b0;
                        end
                        OP_SUB: begin
                            con_s[B_EU]  = 1'b1;
                            con_s[B_SU]  = 1'b1;
                            con_s[B_NLA] = 1'b0;
                        end
                        default: con_s = CON_IDLE;
                    endcase
                end
                default: con_s = CON_IDLE;
            endcase
        end
    end

    assign bus.con  = con_s;
    assign bus.halt = (mode_q == MODE_HALT);
    assign bus.exec = (mode_q == MODE_EXEC);
    assign bus.err  = err_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: walks instructions through the T-states and
// compares control word and status flags against hand-computed values.
module tb_control_sequencer;
    logic CLK;
    logic nCLR;
    int   cmp_count;
    int   fail_count;

    control_sequencer_if bus ();

    control_sequencer dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Ring counter side: new T-state and opcode appear just after the falling edge
    task automatic drive(input logic [3:0] st, input logic [3:0] op);
        @(negedge CLK);
        bus.state  = st;
        bus.opcode = op;
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nCLR = 1'b0;
        bus.state  = 4'b0001;
        bus.opcode = 4'b1110;
        #1;
        cmp_count++;
        if (bus.con !== 12'h3E3) begin
            fail_count++;
            $display("FAIL reset_con_during: got %h expected %h", bus.con, 12'h3E3);
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if ({bus.halt, bus.exec, bus.err} !== 3'b000) begin
            fail_count++;
            $display("FAIL reset_flags: got %b expected %b", {bus.halt, bus.exec, bus.err}, 3'b000);
        end
        cmp_count++;
        if (dut.op_q !== 4'b0000) begin
            fail_count++;
            $display("FAIL reset_op_q: got %h expected %h", dut.op_q, 4'b0000);
        end
        nCLR = 1'b1;
    endtask

    task automatic test_out();
        logic [11:0] exp_con [0:3];
        exp_con[0] = 12'h5E3; exp_con[1] = 12'hBE3; exp_con[2] = 12'h263; exp_con[3] = 12'h3F2;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001 << i, 4'b1110);
            cmp_count++;
            if (bus.con !== exp_con[i] || bus.exec !== 1'b0) begin
                fail_count++;
                $display("FAIL out_t%0d: got con=%h exec=%b expected con=%h exec=0", i + 1, bus.con, bus.exec, exp_con[i]);
            end
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b0 || bus.halt !== 1'b0) begin
            fail_count++;
            $display("FAIL out_after: got exec=%b halt=%b expected 0 0", bus.exec, bus.halt);
        end
    endtask

    task automatic test_lda();
        logic [11:0] exp_con [0:7];
        logic        exp_exec [0:7];
        exp_con[0] = 12'h5E3; exp_con[1] = 12'hBE3; exp_con[2] = 12'h263; exp_con[3] = 12'h1A3;
        exp_con[4] = 12'h2C3; exp_con[5] = 12'h3E3; exp_con[6] = 12'h3E3; exp_con[7] = 12'h3E3;
        for (int i = 0; i < 8; i++) exp_exec[i] = (i >= 4);
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001 << (i % 4), 4'b0000);
            cmp_count++;
            if (bus.con !== exp_con[i] || bus.exec !== exp_exec[i]) begin
                fail_count++;
                $display("FAIL lda_step%0d: got con=%h exec=%b expected con=%h exec=%b", i, bus.con, bus.exec, exp_con[i], exp_exec[i]);
            end
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b0) begin
            fail_count++;
            $display("FAIL lda_exec_end: got %b expected 0", bus.exec);
        end
    endtask

    // Exec pass drives a different opcode to prove the latched one is used
    task automatic test_alu(input logic [3:0] op, input logic [11:0] t2_con);
        logic [11:0] exp_con [0:7];
        exp_con[0] = 12'h5E3; exp_con[1] = 12'hBE3; exp_con[2] = 12'h263; exp_con[3] = 12'h1A3;
        exp_con[4] = 12'h2E1; exp_con[5] = t2_con;  exp_con[6] = 12'h3E3; exp_con[7] = 12'h3E3;
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001 << (i % 4), (i < 4) ? op : 4'b1110 - op);
            cmp_count++;
            if (bus.con !== exp_con[i]) begin
                fail_count++;
                $display("FAIL alu_op%h_step%0d: got %h expected %h", op, i, bus.con, exp_con[i]);
            end
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b0) begin
            fail_count++;
            $display("FAIL alu_op%h_exec_end: got %b expected 0", op, bus.exec);
        end
    endtask

    task automatic test_halt();
        logic [11:0] exp_con [0:3];
        exp_con[0] = 12'h5E3; exp_con[1] = 12'hBE3; exp_con[2] = 12'h263; exp_con[3] = 12'h3E3;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001 << i, 4'b1111);
            cmp_count++;
            if (bus.con !== exp_con[i] || bus.halt !== 1'b0) begin
                fail_count++;
                $display("FAIL hlt_fetch_t%0d: got con=%h halt=%b expected con=%h halt=0", i + 1, bus.con, bus.halt, exp_con[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive(4'b0001 << (i % 4), 4'b1110);
            cmp_count++;
            if (bus.con !== 12'h3E3 || bus.halt !== 1'b1) begin
                fail_count++;
                $display("FAIL hlt_hold%0d: got con=%h halt=%b expected con=3e3 halt=1", i, bus.con, bus.halt);
            end
        end
        test_reset();
        drive(4'b0001, 4'b1110);
        cmp_count++;
        if (bus.con !== 12'h5E3 || bus.halt !== 1'b0) begin
            fail_count++;
            $display("FAIL hlt_resume: got con=%h halt=%b expected con=5e3 halt=0", bus.con, bus.halt);
        end
        for (int i = 1; i < 4; i++) drive(4'b0001 << i, 4'b1110);
    endtask

    task automatic test_illegal();
        drive(4'b0000, 4'b1110);
        cmp_count++;
        if (bus.con !== 12'h3E3) begin
            fail_count++;
            $display("FAIL idle_con: got %h expected %h", bus.con, 12'h3E3);
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.err !== 1'b0) begin
            fail_count++;
            $display("FAIL idle_err: got %b expected 0", bus.err);
        end
        drive(4'b0011, 4'b1110);
        cmp_count++;
        if (bus.con !== 12'h3E3) begin
            fail_count++;
            $display("FAIL illegal_con: got %h expected %h", bus.con, 12'h3E3);
        end
        // LDA with an illegal code in place of the exec T4: exec must be retained
        for (int i = 0; i < 7; i++) begin
            drive(4'b0001 << (i % 4), 4'b0000);
            cmp_count++;
            if (bus.err !== 1'b1) begin
                fail_count++;
                $display("FAIL err_sticky%0d: got %b expected 1", i, bus.err);
            end
        end
        drive(4'b1100, 4'b0000);
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b1) begin
            fail_count++;
            $display("FAIL illegal_hold_exec: got %b expected 1", bus.exec);
        end
        drive(4'b1000, 4'b0000);
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b0 || bus.err !== 1'b1) begin
            fail_count++;
            $display("FAIL illegal_exec_end: got exec=%b err=%b expected 0 1", bus.exec, bus.err);
        end
        test_reset();
    endtask

    task automatic test_reset_mid_exec();
        for (int i = 0; i < 4; i++) drive(4'b0001 << i, 4'b0001);
        @(negedge CLK);
        bus.state  = 4'b0001;
        nCLR = 1'b0;
        #1;
        cmp_count++;
        if (bus.con !== 12'h3E3 || bus.exec !== 1'b1) begin
            fail_count++;
            $display("FAIL rst_exec_con: got con=%h exec=%b expected con=3e3 exec=1", bus.con, bus.exec);
        end
        @(posedge CLK);
        #1;
        cmp_count++;
        if (bus.exec !== 1'b0 || dut.op_q !== 4'b0000) begin
            fail_count++;
            $display("FAIL rst_exec_after: got exec=%b op_q=%h expected exec=0 op_q=0", bus.exec, dut.op_q);
        end
        nCLR = 1'b1;
        drive(4'b0001, 4'b1110);
        cmp_count++;
        if (bus.con !== 12'h5E3) begin
            fail_count++;
            $display("FAIL rst_exec_resume: got %h expected %h", bus.con, 12'h5E3);
        end
        for (int i = 1; i < 4; i++) drive(4'b0001 << i, 4'b1110);
    endtask

    initial begin
        cmp_count  = 0;
        fail_count = 0;
        nCLR       = 1'b0;
        bus.state  = 4'b0000;
        bus.opcode = 4'b0000;
        test_reset();
        test_out();
        test_lda();
        test_alu(4'b0001, 12'h3C7);
        test_alu(4'b0010, 12'h3CF);
        test_halt();
        test_illegal();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
